// File: rtl/ris_ctrl_pkg.sv
// Shared definitions for the RIS command sequencer: command field map, opcodes,
// FSM/sweep encodings and the command checksum used when RIS_CMD_CKSUM_EN is defined.
package ris_ctrl_pkg;

  localparam int unsigned OP_LSB   = 20;
  localparam int unsigned CHK_LSB  = 16;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 8;

  localparam logic [NIB_W-1:0] OP_WRITE  = 4'h1;
  localparam logic [NIB_W-1:0] OP_COMMIT = 4'h2;
  localparam logic [NIB_W-1:0] OP_CLEAR  = 4'h3;
  localparam logic [NIB_W-1:0] OP_FILL   = 4'h4;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SW_COPY  = 2'd0,
    SW_CLEAR = 2'd1,
    SW_FILL  = 2'd2
  } sweep_t;

  // Decoded command payload (check nibble handled separately)
  typedef struct packed {
    logic [NIB_W-1:0]  op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  function automatic logic [NIB_W-1:0] cmd_cksum(input logic [23:0] w);
    return w[OP_LSB +: NIB_W] ^ w[ADDR_LSB+NIB_W +: NIB_W] ^ w[ADDR_LSB +: NIB_W] ^
           w[DATA_LSB+NIB_W +: NIB_W] ^ w[DATA_LSB +: NIB_W];
  endfunction

endpackage

// File: rtl/ris_cfg_bank.sv
// Two banks of per-element phase registers with a single indexed write port
// and flat read-out of both banks.
module ris_cfg_bank #(
  parameter int unsigned N_ELEM  = 16,
  parameter int unsigned PHASE_W = 2,
  parameter int unsigned IDX_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic                      wbank,
  input  logic [IDX_W-1:0]          widx,
  input  logic [PHASE_W-1:0]        wval,
  output logic [N_ELEM*PHASE_W-1:0] bank0,
  output logic [N_ELEM*PHASE_W-1:0] bank1
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0 <= '0;
      bank1 <= '0;
    end else if (we) begin
      if (wbank) bank1[widx*PHASE_W +: PHASE_W] <= wval;
      else       bank0[widx*PHASE_W +: PHASE_W] <= wval;
    end
  end

endmodule

// File: rtl/ris_cmd_ctrl.sv
// RIS command sequencer: decodes command words, edits the shadow bank, swaps banks on COMMIT
// and re-syncs shadow with a one-element-per-cycle sweep. Optional checksum: RIS_CMD_CKSUM_EN.
module ris_cmd_ctrl
  import ris_ctrl_pkg::*;
#(
  parameter int unsigned W_IN    = 24,
  parameter int unsigned N_ELEM  = 16,
  parameter int unsigned PHASE_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  input  logic [W_IN-1:0]           s_data,
  output logic [N_ELEM*PHASE_W-1:0] elem_cfg,
  output logic                      cfg_update,
  output logic                      busy,
  output logic [7:0]                err_cnt
);

  localparam int unsigned IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int unsigned CFG_W = N_ELEM * PHASE_W;

  state_t               state;
  sweep_t               sweep_kind;
  logic [IDX_W-1:0]     cnt;
  logic                 bank_sel;
  logic [PHASE_W-1:0]   fill_val;
  logic                 pend_vld;
  logic [NIB_W-1:0]     pend_op;
  logic [IDX_W-1:0]     pend_idx;
  logic [PHASE_W-1:0]   pend_phase;

  cmd_t                 cmd;
  logic                 legal, accept, drop, sweep_pend;
  logic                 we, wbank;
  logic [IDX_W-1:0]     widx;
  logic [PHASE_W-1:0]   wval, active_elem;
  logic [CFG_W-1:0]     bank0, bank1, active;

  assign busy     = (state == SWEEP);
  assign elem_cfg = active;

  // Command decode and accept/drop decision
  always_comb begin
    cmd.op   = s_data[OP_LSB +: NIB_W];
    cmd.addr = s_data[ADDR_LSB +: ADDR_W];
    cmd.data = s_data[DATA_LSB +: DATA_W];
    legal    = 1'b0;
    case (cmd.op)
      OP_WRITE:                     legal = (32'(cmd.addr) < N_ELEM);
      OP_COMMIT, OP_CLEAR, OP_FILL: legal = 1'b1;
      default:                      legal = 1'b0;
    endcase
`ifdef RIS_CMD_CKSUM_EN
    if (cmd_cksum(24'(s_data)) != s_data[CHK_LSB +: NIB_W]) legal = 1'b0;
`endif
    // A queued sweep-starting command wins over anything arriving right behind it
    sweep_pend = pend_vld && (pend_op != OP_WRITE);
    accept     = s_valid && legal && !busy && !sweep_pend;
    drop       = s_valid && !accept;
  end

`ifdef RIS_CMD_CKSUM_EN
  logic unused_bits;
  assign unused_bits = ^cmd.data;
`else
  logic unused_bits;
  assign unused_bits = ^{cmd.data, s_data[CHK_LSB +: NIB_W]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sweep_kind <= SW_COPY;
      cnt        <= '0;
      bank_sel   <= 1'b0;
      fill_val   <= '0;
      pend_vld   <= 1'b0;
      pend_op    <= '0;
      pend_idx   <= '0;
      pend_phase <= '0;
      cfg_update <= 1'b0;
      err_cnt    <= '0;
    end else begin
      cfg_update <= 1'b0;
      pend_vld   <= accept;
      if (accept) begin
        pend_op    <= cmd.op;
        pend_idx   <= cmd.addr[IDX_W-1:0];
        pend_phase <= cmd.data[PHASE_W-1:0];
      end
      if (drop && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (sweep_pend) begin
            state    <= SWEEP;
            cnt      <= '0;
            fill_val <= pend_phase;
            case (pend_op)
              OP_COMMIT: begin
                bank_sel   <= ~bank_sel;
                cfg_update <= 1'b1;
                sweep_kind <= SW_COPY;
              end
              OP_CLEAR: sweep_kind <= SW_CLEAR;
              default:  sweep_kind <= SW_FILL;
            endcase
          end
        end
        SWEEP: begin
          cnt <= cnt + IDX_W'(1);
          if (cnt == IDX_W'(N_ELEM - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shadow write port: sweep has priority; a pending WRITE only exists in IDLE
  always_comb begin
    active      = bank_sel ? bank1 : bank0;
    active_elem = active[cnt*PHASE_W +: PHASE_W];
    we          = 1'b0;
    wbank       = ~bank_sel;
    widx        = pend_idx;
    wval        = pend_phase;
    if (state == SWEEP) begin
      we   = 1'b1;
      widx = cnt;
      case (sweep_kind)
        SW_COPY:  wval = active_elem;
        SW_CLEAR: wval = '0;
        default:  wval = fill_val;
      endcase
    end else if (pend_vld && (pend_op == OP_WRITE)) begin
      we = 1'b1;
    end
  end

  ris_cfg_bank #(
    .N_ELEM  (N_ELEM),
    .PHASE_W (PHASE_W),
    .IDX_W   (IDX_W)
  ) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .wbank (wbank),
    .widx  (widx),
    .wval  (wval),
    .bank0 (bank0),
    .bank1 (bank1)
  );

endmodule

// File: tb/tb_ris_cmd_ctrl.sv
// Scoreboard bench for ris_cmd_ctrl: each COMMIT pushes the expected active image,
// a monitor pops it on every cfg_update pulse; sweep length and err_cnt are checked inline.
module tb_ris_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_valid = 1'b0;
  logic [23:0] s_data = '0;
  logic [31:0] elem_cfg;
  logic        cfg_update;
  logic        busy;
  logic [7:0]  err_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_err = 8'd0;

  ris_cmd_ctrl #(.W_IN(24), .N_ELEM(16), .PHASE_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .elem_cfg   (elem_cfg),
    .cfg_update (cfg_update),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic [3:0] op, input logic [7:0] addr, input logic [7:0] data);
    logic [3:0] c;
    c = op ^ addr[7:4] ^ addr[3:0] ^ data[7:4] ^ data[3:0];
    return {op, c, addr, data};
  endfunction

  // Called at a negedge; holds the word across one posedge, returns at the next negedge
  task automatic drive(input logic [23:0] w);
    s_valid = 1'b1;
    s_data  = w;
    @(negedge clk);
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic send(input logic [23:0] w);
    drive(w);
    idle();
  endtask

  task automatic commit(input logic [31:0] exp_img);
    exp_q.push_back(exp_img);
    send(mk(4'h2, 8'h00, 8'h00));
  endtask

  task automatic wait_sweep(input string name);
    int  n;
    bit  ended;
    n = 0;
    ended = 0;
    for (int i = 0; i < 60 && !ended; i++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) ended = 1;
    end
    chk({name, "_busy_len"}, 32'(n), 32'd16);
  endtask

  // Monitor: every activation pulse must match the oldest expected image
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && cfg_update) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cfg_update", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("elem_cfg_at_update", elem_cfg, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_elem_cfg", elem_cfg, 32'h0);
    chk("rst_cfg_update", 32'(cfg_update), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write then commit
    send(mk(4'h1, 8'h05, 8'h03));
    commit(32'h0000_0C00);
    wait_sweep("t1");
    chk("t1_err", 32'(err_cnt), 32'(exp_err));

    // Fill, commit, clear, commit
    send(mk(4'h4, 8'h00, 8'h02));
    wait_sweep("t2_fill");
    chk("t2_fill_active_unchanged", elem_cfg, 32'h0000_0C00);
    commit(32'hAAAA_AAAA);
    wait_sweep("t2_commit1");
    send(mk(4'h3, 8'h00, 8'h00));
    wait_sweep("t2_clear");
    chk("t2_clear_active_unchanged", elem_cfg, 32'hAAAA_AAAA);
    commit(32'h0000_0000);
    wait_sweep("t2_commit2");

    // Writes on every busy cycle after a commit are all dropped
    send(mk(4'h4, 8'h00, 8'h01));
    wait_sweep("t3_fill");
    commit(32'h5555_5555);
    @(negedge clk);
    chk("t3_busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) drive(mk(4'h1, 8'(i), 8'h03));
    idle();
    exp_err = exp_err + 8'd16;
    chk("t3_busy_end", 32'(busy), 32'd0);
    chk("t3_err", 32'(err_cnt), 32'(exp_err));
    commit(32'h5555_5555);
    wait_sweep("t3_recommit");

    // Out-of-range address and unknown opcode
    send(mk(4'h1, 8'h10, 8'h03));
    send(mk(4'h7, 8'h05, 8'h03));
    exp_err = exp_err + 8'd2;
    chk("t4_err", 32'(err_cnt), 32'(exp_err));
    commit(32'h5555_5555);
    wait_sweep("t4_commit");

    // err_cnt saturation
    for (int i = 0; i < 240; i++) drive(mk(4'h0, 8'h00, 8'h00));
    idle();
    chk("sat_err", 32'(err_cnt), 32'd255);
    send(mk(4'h9, 8'h00, 8'h00));
    chk("sat_hold", 32'(err_cnt), 32'd255);

    // Reset in the middle of a sweep
    send(mk(4'h1, 8'h00, 8'h02));
    commit(32'h5555_5556);
    n = 0;
    for (int i = 0; i < 40 && n < 8; i++) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("t5_reached_sweep8", 32'(n), 32'd8);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_elem_cfg", elem_cfg, 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_err", 32'(err_cnt), 32'd0);
    exp_err = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(mk(4'h1, 8'h05, 8'h03));
    commit(32'h0000_0C00);
    wait_sweep("t5_again");
    chk("t5_err", 32'(err_cnt), 32'd0);

`ifdef RIS_CMD_CKSUM_EN
    // Checksum gate
    send(24'h17_05_03);
    chk("t6_good_cksum_err", 32'(err_cnt), 32'd0);
    send(24'h16_05_03);
    chk("t6_bad_cksum_err", 32'(err_cnt), 32'd1);
    send(mk(4'h1, 8'h00, 8'h01));
    commit(32'h0000_0C01);
    wait_sweep("t6_commit");
`else
    // Check nibble is ignored
    send({4'h1, 4'hC, 8'h00, 8'h01});
    chk("t6_nocksum_err", 32'(err_cnt), 32'd0);
    commit(32'h0000_0C01);
    wait_sweep("t6_commit");
`endif

    chk("updates_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
